fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the byte address fetched first after start.
REQ-002 SHALL have parameter MEM_WORDS, default 64, the instruction memory depth in 32-bit words.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse; leaves IDLE and begins fetching.
REQ-007 stop  input  1  returns the block to IDLE.
REQ-008 load_we  input  1  loader write strobe; honoured only in IDLE.
REQ-009 load_addr  input  32  loader byte address.
REQ-010 load_data  input  32  loader write word.
REQ-011 mem_addr  output  6  word index to instruction memory (clog2(MEM_WORDS) bits).
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_wdata  output  32  memory write data.
REQ-014 mem_rdata  input  32  combinational read data for mem_addr.
REQ-015 redirect_valid  input  1  branch/jump redirect request.
REQ-016 redirect_target  input  32  redirect byte address.
REQ-017 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-018 out_ready  input  1  consumer accepts the instruction this cycle.
REQ-019 out_instr  output  32  fetched instruction.
REQ-020 out_pc  output  32  byte address of out_instr.
REQ-021 busy  output  1  high whenever state is not IDLE.
REQ-022 fault  output  1  sticky error flag.

Function
REQ-023 SHALL implement states IDLE, RUN and FAULT.
REQ-024 Address mapping SHALL be word index = byte address / 4, i.e. the low bits of byte address[31:2]; byte addresses are legal only when < 4*MEM_WORDS and word-aligned.
REQ-025 IDLE: mem_addr = load_addr word index; mem_we = load_we; mem_wdata = load_data; out_valid = 0.
REQ-026 IDLE: a load_we to an illegal address SHALL be suppressed (mem_we = 0) and SHALL set fault without a state change.
REQ-027 IDLE with start = 1 SHALL go to RUN next cycle with pc unchanged; a simultaneous load_we SHALL still be written.
REQ-028 RUN: mem_addr = pc word index; mem_we = 0; load_we SHALL be ignored.
REQ-029 RUN advance condition = (out_valid == 0 or out_ready == 1); on advance, next cycle out_instr = mem_rdata, out_pc = pc, out_valid = 1, and pc = pc + 4.
REQ-030 Fetch latency SHALL be one cycle: the instruction at pc appears on out_* on the edge after pc is presented.
REQ-031 RUN with out_valid = 1 and out_ready = 0 SHALL hold pc, out_instr, out_pc and out_valid unchanged (stall).
REQ-032 redirect_valid in RUN SHALL set pc = redirect_target and out_valid = 0 next cycle regardless of out_ready; the word fetched that cycle is discarded.
REQ-033 A redirect_target that is not word-aligned or is >= 4*MEM_WORDS SHALL transition to FAULT instead.
REQ-034 RUN on advance with pc >= 4*MEM_WORDS SHALL transition to FAULT and SHALL clear out_valid.
REQ-035 Priority in RUN SHALL be stop > redirect_valid > advance/stall.
REQ-036 stop in RUN SHALL go to IDLE, clear out_valid and retain pc.
REQ-037 start in RUN SHALL be ignored.
REQ-038 FAULT: out_valid = 0, mem_we = 0, fault = 1; only reset exits FAULT.
REQ-039 fault SHALL remain set until reset.
REQ-040 pc arithmetic SHALL be 32-bit and wrap modulo 2^32; the range check catches overflow before any fetch.

Reset
REQ-041 reset SHALL take priority over all inputs.
REQ-042 Reset values: state = IDLE, pc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, fault = 0, busy = 0.
REQ-043 Reset asserted mid-RUN or in FAULT SHALL discard any held instruction and restore the reset values on the next edge.

Verification
REQ-044 Load 0x8C22000C at addr 0 and 0x00000000 at addr 4 in IDLE, then pulse start with out_ready = 1 -> out_instr = 8C22000C / out_pc = 0, then 00000000 / 4, on consecutive cycles.
REQ-045 out_ready = 0 for 3 cycles while out_valid = 1 -> out_pc stays 0 and pc stays 4; release -> out_pc 4, then 8.
REQ-046 redirect_valid with target 0x10 while stalled -> next cycle out_valid = 0; following cycle out_pc = 0x10.
REQ-047 redirect target 0x102 -> FAULT, fault = 1, out_valid = 0; start is ignored until reset.
REQ-048 Run sequentially to pc = 0x100 with MEM_WORDS = 64 -> FAULT after out_pc = 0xFC is delivered; load_we to 0x100 in IDLE -> mem_we = 0 and fault = 1.
REQ-049 stop and redirect_valid in the same cycle -> IDLE, busy = 0, pc unchanged.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: loads instruction memory in IDLE, then streams fetched words with pc out a valid/ready port.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int MEM_WORDS = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic redirect_valid,
  input  logic [31:0] redirect_target,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic busy,
  output logic fault
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  state_t state;
  logic [31:0] pc;
  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < LIMIT);
  endfunction
  always_comb begin
    mem_addr = (state == IDLE) ? load_addr[AW+1:2] : pc[AW+1:2];
    mem_we = (state == IDLE) && load_we && legal(load_addr);
    mem_wdata = load_data;
  end
  assign busy = (state != IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc <= 32'h0;
      fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (load_we && !legal(load_addr)) fault <= 1'b1;
          if (start) state <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            out_valid <= 1'b0;
          end else if (redirect_valid) begin
            out_valid <= 1'b0;
            if (legal(redirect_target)) pc <= redirect_target;
            else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (!out_valid || out_ready) begin
            // Range check precedes the fetch so a wrapped or runaway pc never reaches memory.
            if (pc >= LIMIT) begin
              state <= FAULT;
              fault <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_instr <= mem_rdata;
              out_pc <= pc;
              out_valid <= 1'b1;
              pc <= pc + 32'd4;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          fault <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vectors against a behavioural instruction memory.
module tb_fetch_controller;
  logic clk = 1'b0;
  logic reset, start, stop, load_we, redirect_valid, out_ready;
  logic [31:0] load_addr, load_data, redirect_target, mem_rdata, mem_wdata, out_instr, out_pc;
  logic [5:0] mem_addr;
  logic mem_we, out_valid, busy, fault;
  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_pc;
  logic done;
  always #5 clk = ~clk;
  fetch_controller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .busy(busy), .fault(fault)
  );
  always_ff @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; start = 0; stop = 0; load_we = 0; load_addr = 0; load_data = 0;
    redirect_valid = 0; redirect_target = 0; out_ready = 0;
    tick(); tick();
    reset = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    load_we = 1; load_addr = 0; load_data = 32'h8C22000C;
    #1;
    chk("load_we0", 32'(mem_we), 1);
    chk("load_addr0", 32'(mem_addr), 0);
    tick();
    load_addr = 4; load_data = 0;
    #1;
    chk("load_addr1", 32'(mem_addr), 1);
    tick();
    for (int i = 2; i < 64; i++) begin
      load_addr = 32'(i * 4); load_data = 32'hA5A50000 | 32'(i);
      tick();
    end
    load_we = 0;
    chk("idle_busy", 32'(busy), 0);
    start = 1; out_ready = 1;
    tick();
    start = 0;
    chk("run_busy", 32'(busy), 1);
    chk("run_novalid", 32'(out_valid), 0);
    tick();
    chk("f0_valid", 32'(out_valid), 1);
    chk("f0_instr", out_instr, 32'h8C22000C);
    chk("f0_pc", out_pc, 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", out_pc, 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_addr", 32'(mem_addr), 1);
    end
    out_ready = 1;
    tick();
    chk("f1_pc", out_pc, 4);
    chk("f1_instr", out_instr, 0);
    tick();
    chk("f2_pc", out_pc, 8);
    chk("f2_instr", out_instr, 32'hA5A50002);
    out_ready = 0;
    tick();
    chk("hold_pc", out_pc, 8);
    redirect_valid = 1; redirect_target = 32'h10;
    tick();
    redirect_valid = 0;
    chk("redir_valid", 32'(out_valid), 0);
    chk("redir_addr", 32'(mem_addr), 4);
    tick();
    chk("redir_pc", out_pc, 32'h10);
    chk("redir_instr", out_instr, 32'hA5A50004);
    stop = 1; redirect_valid = 1; redirect_target = 32'h20;
    tick();
    stop = 0; redirect_valid = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_valid", 32'(out_valid), 0);
    start = 1; out_ready = 1;
    tick();
    start = 0;
    tick();
    chk("resume_pc", out_pc, 32'h14);
    chk("resume_instr", out_instr, 32'hA5A50005);
    redirect_valid = 1; redirect_target = 32'h102;
    tick();
    redirect_valid = 0;
    chk("badredir_fault", 32'(fault), 1);
    chk("badredir_valid", 32'(out_valid), 0);
    start = 1; load_we = 1; load_addr = 0; load_data = 32'hDEADBEEF;
    #1;
    chk("fault_we", 32'(mem_we), 0);
    tick();
    start = 0; load_we = 0;
    tick();
    chk("fault_stay_busy", 32'(busy), 1);
    chk("fault_stay_valid", 32'(out_valid), 0);
    chk("fault_sticky", 32'(fault), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst2_fault", 32'(fault), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_pc", out_pc, 0);
    chk("rst2_instr", out_instr, 0);
    start = 1; out_ready = 1;
    tick();
    start = 0;
    last_pc = 32'hFFFFFFFF; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (out_valid) last_pc = out_pc;
      if (fault) done = 1;
    end
    chk("seq_fault", 32'(fault), 1);
    chk("seq_last_pc", last_pc, 32'hFC);
    chk("seq_valid", 32'(out_valid), 0);
    reset = 1;
    tick();
    reset = 0;
    load_we = 1; load_addr = 32'h100; load_data = 32'h12345678;
    #1;
    chk("oob_we", 32'(mem_we), 0);
    tick();
    load_we = 0;
    chk("oob_fault", 32'(fault), 1);
    chk("oob_busy", 32'(busy), 0);
    load_we = 1; load_addr = 32'h2;
    #1;
    chk("misalign_we", 32'(mem_we), 0);
    tick();
    load_we = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
